// File: rtl/dm_defs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dm_defs                                                            |
// | Shared dm_ctrl codes, FSM state encoding and bus-timeout default.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package dm_defs;

    localparam logic [2:0] c_dm_word  = 3'b000;
    localparam logic [2:0] c_dm_half  = 3'b001;
    localparam logic [2:0] c_dm_halfu = 3'b010;
    localparam logic [2:0] c_dm_byte  = 3'b011;
    localparam logic [2:0] c_dm_byteu = 3'b100;
    localparam logic [2:0] c_dm_none  = 3'b111;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam int unsigned c_default_timeout_cyc = 255;

    // Codes 101 and 110 are reserved and behave like "none".
    function automatic logic dm_is_access(input logic [2:0] ctrl);
        return (ctrl <= c_dm_byteu);
    endfunction

    function automatic logic dm_is_aligned(input logic [2:0] ctrl, input logic [1:0] off);
        logic ok;
        case (ctrl)
            c_dm_word:             ok = (off == 2'b00);
            c_dm_half, c_dm_halfu: ok = ~off[0];
            default:               ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dm_lane_align                                                      |
// | Byte-enable generation, store-data replication, load extraction.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module dm_lane_align
    import dm_defs::*;
(
    input  logic [2:0]  i_dm_ctrl,
    input  logic [1:0]  i_byte_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_bus_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata_rep,
    output logic [31:0] o_rdata_ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte      = i_bus_rdata[{i_byte_off, 3'b000} +: 8];
        w_half      = i_byte_off[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        o_be        = 4'b0000;
        o_wdata_rep = 32'h0000_0000;
        o_rdata_ext = 32'h0000_0000;
        case (i_dm_ctrl)
            c_dm_word: begin
                o_be        = 4'b1111;
                o_wdata_rep = i_wdata;
                o_rdata_ext = i_bus_rdata;
            end
            c_dm_half, c_dm_halfu: begin
                o_be        = i_byte_off[1] ? 4'b1100 : 4'b0011;
                o_wdata_rep = {2{i_wdata[15:0]}};
                o_rdata_ext = {{16{w_half[15] & (i_dm_ctrl == c_dm_half)}}, w_half};
            end
            c_dm_byte, c_dm_byteu: begin
                o_be        = 4'b0001 << i_byte_off;
                o_wdata_rep = {4{i_wdata[7:0]}};
                o_rdata_ext = {{24{w_byte[7] & (i_dm_ctrl == c_dm_byte)}}, w_byte};
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dm_bus_access.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dm_bus_access                                                      |
// | MEM-stage load/store engine: IDLE/BUSY/DONE bus handshake w/ abort.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module dm_bus_access
    import dm_defs::*;
#(
    parameter int unsigned TIMEOUT_CYC = c_default_timeout_cyc
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        mem_w,
    input  logic [2:0]  dm_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [8:0] c_timeout_cyc = 9'(TIMEOUT_CYC);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic [2:0]  r_ctrl;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic [1:0]  w_state_nxt;
    logic        w_accept;
    logic        w_misalign;
    logic        w_timeout;
    logic        w_busy;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_rdata_ext;

    dm_lane_align u_lane_align (
        .i_dm_ctrl   (r_ctrl),
        .i_byte_off  (r_addr[1:0]),
        .i_wdata     (r_wdata),
        .i_bus_rdata (bus_rdata),
        .o_be        (w_be),
        .o_wdata_rep (w_wdata_rep),
        .o_rdata_ext (w_rdata_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= 8'd0;
            r_we    <= 1'b0;
            r_ctrl  <= c_dm_none;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt   <= 8'd0;
                r_we    <= mem_w;
                r_ctrl  <= dm_ctrl;
                r_addr  <= addr;
                r_wdata <= wdata;
            end else if (w_busy && !bus_ack) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_busy && bus_ack && !r_we) begin
                r_rdata <= w_rdata_ext;
            end
        end
    end

    // Timeout compares against the count including the current BUSY cycle,
    // so an ack arriving on that very cycle still wins.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_misalign  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (req_valid && dm_is_access(dm_ctrl)) begin
                    if (dm_is_aligned(dm_ctrl, addr[1:0])) begin
                        w_accept    = 1'b1;
                        w_state_nxt = c_st_busy;
                    end else begin
                        w_misalign = 1'b1;
                    end
                end
            end
            c_st_busy: begin
                if (bus_ack) begin
                    w_state_nxt = c_st_done;
                end else if (({1'b0, r_cnt} + 9'd1) == c_timeout_cyc) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    assign w_busy = (r_state == c_st_busy);

    // IDLE-phase outputs depend on live inputs; mask them while reset is held.
    assign stall     = !rst && (w_accept || w_busy);
    assign misalign  = !rst && w_misalign;
    assign done      = (r_state == c_st_done);
    assign bus_err   = w_timeout;
    assign rdata     = r_rdata;
    assign bus_req   = w_busy;
    assign bus_we    = w_busy && r_we;
    assign bus_addr  = w_busy ? {r_addr[31:2], 2'b00} : 32'h0;
    assign bus_be    = w_busy ? w_be : 4'b0000;
    assign bus_wdata = w_busy ? w_wdata_rep : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_dm_bus_access.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dm_bus_access                                                   |
// | Random + directed scoreboard bench for dm_bus_access.              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_dm_bus_access;

    localparam int c_to = 4;
    localparam int K_BUS = 0, K_DONE = 1, K_ERR = 2, K_MIS = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, mem_w;
    logic [2:0]  dm_ctrl;
    logic [31:0] addr, wdata;
    logic        stall, done, misalign, bus_err;
    logic [31:0] rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          g_ack_delay = 0;
    logic [31:0] g_rd = 32'h0;
    logic [31:0] last_rdata = 32'h0;
    ev_t         exp_q[$];

    dm_bus_access #(.TIMEOUT_CYC(c_to)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .mem_w(mem_w),
        .dm_ctrl(dm_ctrl), .addr(addr), .wdata(wdata), .stall(stall),
        .rdata(rdata), .done(done), .misalign(misalign), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic take(input int kind, input string nm, output ev_t e, output bit ok);
        n_checks++;
        ok = 1'b0;
        e  = '{default: '0};
        if (exp_q.size() == 0 || exp_q[0].kind != kind) begin
            n_err++;
            $display("FAIL %s @cyc %0d: unexpected event, got kind %0d expected kind %0d",
                     nm, cyc, kind, (exp_q.size() == 0) ? -1 : exp_q[0].kind);
        end else begin
            e  = exp_q.pop_front();
            ok = 1'b1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_misalign"}, 32'(misalign), 0);
        chk({tag, "_bus_err"}, 32'(bus_err), 0);
        chk({tag, "_bus_req"}, 32'(bus_req), 0);
        chk({tag, "_bus_we"}, 32'(bus_we), 0);
        chk({tag, "_bus_addr"}, bus_addr, 0);
        chk({tag, "_bus_be"}, 32'(bus_be), 0);
        chk({tag, "_bus_wdata"}, bus_wdata, 0);
        chk({tag, "_rdata"}, rdata, 0);
    endtask

    // Reference model: one request in, a list of expected observable events out.
    task automatic do_req(input logic we, input logic [2:0] ctrl, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int delay);
        int          size, n;
        bit          access, aligned, sgn;
        logic [31:0] mask, v;
        ev_t         e;
        @(posedge clk); #1;
        g_ack_delay = delay;
        g_rd        = rd;
        req_valid = 1'b1; mem_w = we; dm_ctrl = ctrl; addr = a; wdata = wd;
        access  = (ctrl <= 3'd4);
        size    = (ctrl == 3'd0) ? 4 : (ctrl <= 3'd2) ? 2 : 1;
        sgn     = (ctrl == 3'd1) || (ctrl == 3'd3);
        aligned = ((a % size) == 0);
        e = '{default: '0};
        if (access && !aligned) begin
            e.kind = K_MIS; e.cyc = cyc;
            exp_q.push_back(e);
        end else if (access) begin
            e.kind  = K_BUS; e.cyc = cyc + 1; e.we = we;
            e.addr  = a & 32'hFFFF_FFFC;
            e.be    = 4'(((1 << size) - 1) << (a % 4));
            e.wdata = (size == 1) ? wd[7:0] * 32'h0101_0101 :
                      (size == 2) ? wd[15:0] * 32'h0001_0001 : wd;
            exp_q.push_back(e);
            if (delay < c_to) begin
                mask = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 1;
                v    = (rd >> (8 * (a % 4))) & mask;
                if (sgn && v > (mask >> 1)) v = v | ~mask;
                if (!we) last_rdata = v;
                e.kind = K_DONE; e.cyc = cyc + 2 + delay; e.rdata = last_rdata;
            end else begin
                e.kind = K_ERR; e.cyc = cyc + c_to;
            end
            exp_q.push_back(e);
        end
        @(negedge clk);
        chk("stall_accept", 32'(stall), 32'(access && aligned));
        @(posedge clk); #1;
        // Junk on the request port while busy must be ignored.
        req_valid = access && aligned && ($urandom % 2 == 1);
        mem_w = 1'($urandom); dm_ctrl = 3'($urandom); addr = $urandom; wdata = $urandom;
        if (access && aligned) begin
            n = (delay < c_to) ? delay + 1 : c_to - 1;
            repeat (n) @(posedge clk);
            #1 req_valid = 1'b0;
        end else begin
            req_valid = 1'b0;
        end
    endtask

    // Bus slave: acks on BUSY cycle index g_ack_delay, random ack noise otherwise.
    initial begin : bus_slave
        int busy_cnt;
        busy_cnt  = 0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (rst || !bus_req) begin
                busy_cnt  = 0;
                bus_ack   = !rst && ($urandom % 2 == 1);
                bus_rdata = $urandom;
            end else begin
                bus_ack   = (busy_cnt == g_ack_delay);
                bus_rdata = bus_ack ? g_rd : $urandom;
                busy_cnt++;
            end
        end
    end

    initial begin : monitor
        bit  in_busy, have_cur, ok;
        ev_t cur, e;
        in_busy = 0; have_cur = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_busy = 0; have_cur = 0;
            end else begin
                if (bus_req) begin
                    if (!in_busy) begin
                        take(K_BUS, "bus_req_start", cur, have_cur);
                        if (have_cur) chk("bus_start_cyc", 32'(cyc), 32'(cur.cyc));
                        in_busy = 1;
                    end
                    if (have_cur) begin
                        chk("bus_we", 32'(bus_we), 32'(cur.we));
                        chk("bus_addr", bus_addr, cur.addr);
                        chk("bus_be", 32'(bus_be), 32'(cur.be));
                        if (cur.we) chk("bus_wdata", bus_wdata, cur.wdata);
                        chk("stall_busy", 32'(stall), 1);
                    end
                end else begin
                    in_busy = 0; have_cur = 0;
                end
                if (bus_err) begin
                    take(K_ERR, "bus_err", e, ok);
                    if (ok) chk("bus_err_cyc", 32'(cyc), 32'(e.cyc));
                    chk("done_with_err", 32'(done), 0);
                end
                if (done) begin
                    take(K_DONE, "done", e, ok);
                    if (ok) begin
                        chk("done_cyc", 32'(cyc), 32'(e.cyc));
                        chk("rdata", rdata, e.rdata);
                    end
                    chk("stall_done", 32'(stall), 0);
                end
                if (misalign) begin
                    take(K_MIS, "misalign", e, ok);
                    if (ok) chk("misalign_cyc", 32'(cyc), 32'(e.cyc));
                    chk("bus_req_mis", 32'(bus_req), 0);
                    chk("stall_mis", 32'(stall), 0);
                end
            end
        end
    end

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        ev_t e;
        rst = 1'b1; req_valid = 1'b0; mem_w = 1'b0; dm_ctrl = 3'b111;
        addr = 32'h0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 check_all_zero("in_rst");
        @(negedge clk); #2 rst = 1'b0;
        @(posedge clk); #1 check_all_zero("after_rst");

        do_req(1'b0, 3'b011, 32'h0000_1003, 32'h0, 32'h80FF_0000, 1);
        do_req(1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 2);
        do_req(1'b0, 3'b000, 32'h0000_3001, 32'h0, 32'h0, 0);
        do_req(1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h1234_5678, 99);
        do_req(1'b0, 3'b100, 32'h0000_5001, 32'h0, 32'h0000_9A00, 0);
        do_req(1'b0, 3'b000, 32'h0000_7000, 32'h0, 32'hCAFE_F00D, c_to - 1);
        do_req(1'b1, 3'b111, 32'h0000_8000, 32'h1, 32'h0, 0);

        for (int i = 0; i < 250; i++) begin
            do_req(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                   $urandom_range(0, c_to + 1));
        end

        // Asynchronous reset in the middle of a bus access.
        @(posedge clk); #1;
        g_ack_delay = 99;
        req_valid = 1'b1; mem_w = 1'b0; dm_ctrl = 3'b000; addr = 32'h0000_6000;
        e = '{default: '0};
        e.kind = K_BUS; e.cyc = cyc + 1; e.addr = 32'h0000_6000; e.be = 4'hF;
        exp_q.push_back(e);
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("rst_bus_req", 32'(bus_req), 0);
        chk("rst_stall", 32'(stall), 0);
        @(negedge clk); #2 rst = 1'b0;
        last_rdata = 32'h0;
        @(posedge clk); #1 check_all_zero("post_mid_rst");

        do_req(1'b0, 3'b001, 32'h0000_9002, 32'h0, 32'h8001_0000, 1);
        repeat (3) @(posedge clk);
        #1 chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
